// File: rtl/fir_sample_feeder.sv
// Producer side of the 64-tap FIR: writes incoming samples into a circular buffer,
// kicks the FIR engine, waits out its latency, then scales and saturates the result.
module fir_sample_feeder #(
  parameter int FIR_LATENCY = 66,
  parameter int SHIFT       = 10
) (
  input  logic               clk_in,
  input  logic               rst_in,
  input  logic signed [15:0] sample_in,
  input  logic               sample_valid_in,
  output logic signed [15:0] sample_out [0:63],
  output logic [5:0]         offset_out,
  output logic               fir_ready_out,
  input  logic signed [25:0] fir_result_in,
  output logic signed [15:0] audio_out,
  output logic               audio_valid_out,
  output logic               busy_out,
  output logic [7:0]         overrun_out
);

  localparam int CNT_W = $clog2(FIR_LATENCY + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT, DONE} state_t;

  state_t             state_reg;
  logic [CNT_W-1:0]   wait_cnt_reg;
  logic [5:0]         offset_reg;
  logic               fir_ready_reg;
  logic signed [15:0] audio_reg;
  logic               audio_valid_reg;
  logic [7:0]         overrun_reg;
  logic               pend_full_reg;
  logic signed [15:0] pend_data_reg;
  logic signed [15:0] buf_reg [0:63];

  logic               write_en;
  logic signed [15:0] write_data;
  logic [5:0]         write_addr;
  logic signed [25:0] shifted;
  logic signed [15:0] scaled;

  assign write_en   = (state_reg == IDLE) && (pend_full_reg || sample_valid_in);
  assign write_data = pend_full_reg ? pend_data_reg : sample_in;
  assign write_addr = offset_reg + 6'd1;

  assign shifted = fir_result_in >>> SHIFT;

  always_comb begin
    scaled = shifted[15:0];
    if (shifted > 26'sd32767)
      scaled = 16'sh7FFF;
    else if (shifted < -26'sd32768)
      scaled = 16'sh8000;
  end

  genvar gi;
  generate
    for (gi = 0; gi < 64; gi++) begin : g_buf
      always_ff @(posedge clk_in) begin
        if (rst_in)
          buf_reg[gi] <= '0;
        else if (write_en && (write_addr == 6'(gi)))
          buf_reg[gi] <= write_data;
      end
      assign sample_out[gi] = buf_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_reg       <= IDLE;
      wait_cnt_reg    <= '0;
      offset_reg      <= '0;
      fir_ready_reg   <= 1'b0;
      audio_reg       <= '0;
      audio_valid_reg <= 1'b0;
      overrun_reg     <= '0;
      pend_full_reg   <= 1'b0;
      pend_data_reg   <= '0;
    end else begin
      fir_ready_reg   <= 1'b0;
      audio_valid_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (write_en) begin
            offset_reg    <= write_addr;
            fir_ready_reg <= 1'b1;
            state_reg     <= START;
          end
          // Pending drains first; a simultaneous new sample refills it.
          if (pend_full_reg) begin
            if (sample_valid_in)
              pend_data_reg <= sample_in;
            else
              pend_full_reg <= 1'b0;
          end
        end
        START: begin
          wait_cnt_reg <= '0;
          state_reg    <= WAIT;
        end
        WAIT: begin
          // Counter starts at 0 in the first WAIT cycle, so DONE lands FIR_LATENCY cycles after the pulse.
          wait_cnt_reg <= wait_cnt_reg + 1'b1;
          if (wait_cnt_reg == CNT_W'(FIR_LATENCY - 2)) begin
            state_reg       <= DONE;
            audio_valid_reg <= 1'b1;
          end
        end
        DONE: begin
          audio_reg <= scaled;
          state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase

      if ((state_reg != IDLE) && sample_valid_in) begin
        if (!pend_full_reg) begin
          pend_full_reg <= 1'b1;
          pend_data_reg <= sample_in;
        end else if (overrun_reg != 8'hFF) begin
          overrun_reg <= overrun_reg + 8'd1;
        end
      end
    end
  end

  assign offset_out      = offset_reg;
  assign fir_ready_out   = fir_ready_reg;
  assign audio_out       = audio_reg;
  assign audio_valid_out = audio_valid_reg;
  assign busy_out        = (state_reg != IDLE);
  assign overrun_out     = overrun_reg;

endmodule

// File: doc/fir_sample_feeder.md
# fir_sample_feeder

Producer side of the 64-tap FIR datapath. Accepts a stream of signed 16-bit audio samples and writes each one into a 64-entry circular sample buffer. It then drives the buffer, the newest-sample offset and a one-cycle start pulse into the FIR engine, waits out the engine's fixed computation latency, and captures, scales and saturates the result into a 16-bit output sample. It sits between the audio sample source and the FIR engine, plus its downstream consumer.

## Interface
Parameters:
- `FIR_LATENCY`, 66: cycles from the `fir_ready_out` pulse to the cycle `fir_result_in` is captured. The engine's result is stable from pulse+65.
- `SHIFT`, 10: arithmetic right shift applied to `fir_result_in` before saturation.

Ports:
- `clk_in`, input, 1: system clock.
- `rst_in`, input, 1: synchronous, active-high reset.
- `sample_in`, input, 16 signed: incoming audio sample.
- `sample_valid_in`, input, 1: `sample_in` is valid this cycle. Single-cycle strobe; no backpressure.
- `sample_out`, output, 16 signed [63:0]: circular buffer contents, to the FIR engine.
- `offset_out`, output, 6: index of the newest sample in `sample_out`.
- `fir_ready_out`, output, 1: one-cycle start pulse to the FIR engine.
- `fir_result_in`, input, 26 signed: FIR engine accumulator output.
- `audio_out`, output, 16 signed: scaled, saturated filter output.
- `audio_valid_out`, output, 1: one-cycle strobe; `audio_out` is new.
- `busy_out`, output, 1: high in every state except IDLE.
- `overrun_out`, output, 8: count of dropped input samples, saturating at 255.

## Operation
- **Reset values:** all buffer entries 0; `offset_out` = 0; `fir_ready_out` = 0; `audio_out` = 0; `audio_valid_out` = 0; `overrun_out` = 0; pending register empty; state IDLE.
- **States:**
  - IDLE: if the pending register is full, or `sample_valid_in` is high, perform the write step and go to START.
  - START: `fir_ready_out` = 1 for exactly this cycle; the wait counter clears; go to WAIT.
  - WAIT: the counter increments each cycle; at counter = `FIR_LATENCY` − 1, go to DONE.
  - DONE: capture and scale `fir_result_in`; `audio_valid_out` = 1 for this cycle; go to IDLE.
- **Write step:**
  - `offset_out` ← `offset_out` + 1 mod 64 (63 wraps to 0).
  - `buf[offset_out+1]` ← the chosen sample. Both update at the same clock edge.
- **Sample priority in IDLE:**
  - The pending sample is used first.
  - If `sample_valid_in` is also high in that cycle, the new sample is loaded into pending.
  - If pending is empty, the new sample is written directly.
- **Samples arriving outside IDLE:**
  - If pending is empty, the sample is stored in pending.
  - If pending is full, the sample is dropped and `overrun_out` increments (saturating at 255).
  - The buffer and `offset_out` never change outside the IDLE write step; they stay stable throughout START/WAIT/DONE.
- **Scaling:**
  - s = `fir_result_in` >>> `SHIFT` (arithmetic shift, sign preserved).
  - `audio_out` = 32767 if s > 32767; −32768 if s < −32768; otherwise s[15:0].
- `audio_out` holds its value until the next DONE.
- **Reset mid-operation:** any state returns to the reset values on the next edge. The pending sample is discarded, and no `audio_valid_out` pulse is issued for the aborted computation.

## Timing
- Let W be the write-step edge in IDLE.
  - New `offset_out` and buffer contents are visible from W+1.
  - `fir_ready_out` is high in cycle W+1 (START).
  - The capture in DONE occurs in cycle W+1+`FIR_LATENCY`, with `audio_valid_out` high in that same cycle.
  - `audio_out` is updated from the following cycle.
- Minimum sample period: `FIR_LATENCY` + 2 cycles. With the default value, a new write can occur in the cycle after DONE, i.e. every 68 cycles.
- A `sample_valid_in` in the DONE cycle goes to pending and is consumed in the following IDLE cycle.
- `fir_ready_out` never asserts in two consecutive cycles.

## Test plan
- **Reset:** hold `rst_in` 3 cycles → all outputs 0, `busy_out` = 0, `offset_out` = 0, all `sample_out` entries 0.
- **Single sample:** `sample_in` = 1000 in IDLE → `offset_out` = 1 and `buf[1]` = 1000 next cycle; `fir_ready_out` pulses once; `busy_out` high for exactly 67 cycles (START through DONE). With a model engine returning 1024000 at capture, `audio_out` = 1000 and `audio_valid_out` pulses in cycle W+67.
- **Wrap-around:** feed 64 samples at 68-cycle spacing → `offset_out` steps 1..63 then wraps to 0; `buf[0]` holds the 64th sample.
- **Back-to-back and overrun:** strobe three samples on consecutive cycles starting in IDLE →
  - first written immediately;
  - second held in pending and written in the IDLE cycle after the first DONE;
  - third dropped, `overrun_out` = 1.
- **Saturation:** `fir_result_in` = 2^25−1 → `audio_out` = 32767. `fir_result_in` = −2^25 → `audio_out` = −32768. `fir_result_in` = −2048 → `audio_out` = −2.
- **Reset mid-WAIT:** assert `rst_in` 20 cycles after `fir_ready_out` with pending full → no `audio_valid_out` pulse; `offset_out` = 0; pending empty; the next sample is written to `buf[1]`.
